// File: rtl/cla_op_sequencer.sv
// cla_op_sequencer: operand sequencer and result capture stage around the
// external 32-bit carry-lookahead adder (CLA_high).
// Requests {a, b, cin} are queued in a small FIFO. They are issued to the
// adder one at a time. The adder result is sampled after ADD_LATENCY edges
// and presented on a valid/ready output stream, in request order.
// Optional feature macro: CLA_OP_SEQ_OVF_EN enables the signed-overflow flag
// on out_ovf. When the macro is undefined, out_ovf is tied low.
`timescale 1ns/1ps

module cla_op_sequencer #(
  parameter int WIDTH       = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] number1,
  output logic [WIDTH-1:0] number2,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam int ENT_W = 2 * WIDTH + 1;

  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAT_INIT      = CNT_W'(ADD_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ready_en_q;

  // Sequencer state and issue / capture registers
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] number1_q, number1_d;
  logic [WIDTH-1:0] number2_q, number2_d;
  logic             cin_q, cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;

  logic             full_s;
  logic             empty_s;
  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             capture_s;
  logic [ENT_W-1:0] head_s;

  assign full_s     = (count_q == FIFO_FULL_CNT);
  assign empty_s    = (count_q == {(PTR_W + 1){1'b0}});
  // ready_en_q keeps in_ready low until the first edge after reset release
  assign in_ready_s = ready_en_q && !full_s && !reset;
  assign push_s     = in_valid && in_ready_s;
  assign head_s     = mem_q[rd_ptr_q];

  assign in_ready  = in_ready_s;
  assign number1   = number1_q;
  assign number2   = number2_q;
  assign cin       = cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

  // Write the incoming request into the FIFO slot at the write pointer
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_a, in_b, in_cin};
    end
  end

  // Next FIFO pointers and occupancy from the push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer: issue the FIFO head, wait out the adder latency, hold the result
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    number1_d   = number1_q;
    number2_d   = number2_q;
    cin_d       = cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture_s   = 1'b1;
          out_sum_d   = sum;
          out_cout_d  = cout;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty_s) begin
            // Next operation issues on the same edge as the handshake
            pop_s   = 1'b1;
            cnt_d   = LAT_INIT;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    // Operands change only when a new request is issued
    if (pop_s) begin
      {number1_d, number2_d, cin_d} = head_s;
    end else begin
      number1_d = number1_q;
      number2_d = number2_q;
      cin_d     = cin_q;
    end
  end

  // State, FIFO bookkeeping and issue/capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_q  <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {(PTR_W + 1){1'b0}};
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      number1_q   <= {WIDTH{1'b0}};
      number2_q   <= {WIDTH{1'b0}};
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      number1_q   <= number1_d;
      number2_q   <= number2_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
    end
  end

`ifdef CLA_OP_SEQ_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic out_ovf_q, out_ovf_d;

  assign out_ovf = out_ovf_q;

  // Track issued operand MSBs and flag signed overflow at result capture
  always_comb begin
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    out_ovf_d = out_ovf_q;
    if (pop_s) begin
      a_msb_d = head_s[ENT_W-1];
      b_msb_d = head_s[WIDTH];
    end else begin
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
    end
    if (capture_s) begin
      out_ovf_d = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
    end else begin
      out_ovf_d = out_ovf_q;
    end
  end

  // Overflow-path registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      out_ovf_q <= out_ovf_d;
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_op_sequencer.sv
// Directed testbench for cla_op_sequencer. It includes a behavioural adder
// that stands in for CLA_high. Expected overflow results depend on
// CLA_OP_SEQ_OVF_EN.
`timescale 1ns/1ps

module tb_cla_op_sequencer;

  localparam int W = 32;
`ifdef CLA_OP_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [W-1:0] number1, number2;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the CLA adder
  assign {cout, sum} = {1'b0, number1} + {1'b0, number2} + {{W{1'b0}}, cin};

  cla_op_sequencer #(.WIDTH(W), .FIFO_DEPTH(4), .ADD_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .number1(number1), .number2(number2), .cin(cin),
    .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic test_reset();
    logic [3*W+4:0] outs;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {in_ready, out_valid, number1, number2, cin, out_sum, out_cout, out_ovf};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", outs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got %b exp 1", in_ready);
    end
    @(negedge clk);
  endtask

  // Single request on an idle sequencer with full latency checking
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready got %b exp 1", nm, in_ready);
    end
    @(negedge clk);  // accept edge E passed
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_early got %b exp 0", nm, out_valid);
    end
    @(negedge clk);  // E+1: operands issued
    checks++;
    if ({number1, number2, cin, out_valid} !== {a, b, c, 1'b0}) begin
      errors++;
      $display("FAIL %s_issue got %h %h %b v%b exp %h %h %b v0", nm, number1, number2, cin, out_valid, a, b, c);
    end
    @(negedge clk);  // E+2: result captured
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, es, ec, eo}) begin
      errors++;
      $display("FAIL %s_result got v%b %h c%b o%b exp v1 %h c%b o%b",
               nm, out_valid, out_sum, out_cout, out_ovf, es, ec, eo);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_clear got %b exp 0", nm, out_valid);
    end
  endtask

  task automatic test_arith();
    do_op("add41_32", 32'd41, 32'd32, 1'b0, 32'd73, 1'b0, 1'b0);
    do_op("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    do_op("cin_only", 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
  endtask

  task automatic test_ovf();
    do_op("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
    do_op("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, OVF_ON);
    do_op("no_ovf", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int  accepted = 0;
    int  got = 0;
    int  last = 0;
    bit  acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 20 && accepted < 5; cyc++) begin
      in_a = W'(accepted + 1); in_b = W'(accepted + 1); in_cin = 1'b0;
      acc = in_ready;
      @(negedge clk);
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 5) begin
      errors++;
      $display("FAIL b2b_accepts got %0d exp 5", accepted);
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({in_ready, out_valid, out_sum, out_cout} !== {1'b0, 1'b1, 32'd2, 1'b0}) begin
        errors++;
        $display("FAIL b2b_stall%0d got r%b v%b %0d c%b exp r0 v1 2 c0", s, in_ready, out_valid, out_sum, out_cout);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (out_valid) begin
        checks++;
        if (out_sum !== W'(2 * (got + 1))) begin
          errors++;
          $display("FAIL b2b_result%0d got %0d exp %0d", got, out_sum, 2 * (got + 1));
        end
        if (got > 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL b2b_spacing%0d got %0d exp 2", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 5", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [3*W+4:0] outs;
    bit seen = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = W'(100 + i); in_b = W'(1); in_cin = 1'b0;
      @(negedge clk);
    end
    // HOLD with two queued; handshake now issues the second and queues a fourth
    out_ready = 1'b1;
    in_a = 32'd103;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({number1, out_valid} !== {32'd101, 1'b0}) begin
      errors++;
      $display("FAIL mid_wait_issue got %0d v%b exp 101 v0", number1, out_valid);
    end
    reset = 1'b1;
    #1;
    outs = {in_ready, out_valid, number1, number2, cin, out_sum, out_cout, out_ovf};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_async got %h exp 0", outs);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_result got %b exp 0", seen);
    end
    do_op("after_reset", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
